// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO management master (one command at a time).
// Define MDIO_PRE_SUPPRESS_EN to skip the 32-bit preamble (32-bit frames).
module mdio_master #(
    parameter int CLK_DIV = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
    output logic [15:0] rd_data,
    output logic        rd_err,
    output logic        done,
    output logic        busy,
    output logic        phy_mdc,
    inout  wire         phy_mdio
);

    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_DONE
    } state_t;

`ifdef MDIO_PRE_SUPPRESS_EN
    localparam state_t FIRST_STATE = S_HDR;
`else
    localparam state_t FIRST_STATE = S_PRE;
`endif

    state_t        state_q, state_d;
    logic          arm_q, arm_d;
    logic [CW-1:0] phase_q, phase_d;
    logic          half_q, half_d;
    logic [4:0]    bit_q, bit_d;
    logic [31:0]   tx_q, tx_d;
    logic          wr_q, wr_d;
    logic [15:0]   rx_q, rx_d;
    logic          ta_q, ta_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic          rd_err_q, rd_err_d;

    logic [4:0]    last_bit;
    logic          mdc_tick;
    logic          mdo;
    logic          mdo_en;

    assign mdc_tick = (phase_q == CW'(CLK_DIV - 1));

    // Index of the final bit in the current frame field.
    always_comb begin
        last_bit = 5'd15;
        case (state_q)
            S_PRE:   last_bit = 5'd31;
            S_HDR:   last_bit = 5'd13;
            S_TA:    last_bit = 5'd1;
            default: last_bit = 5'd15;
        endcase
    end

    // Frame sequencer: MDC phase, bit counting, shifting and read capture.
    always_comb begin
        state_d   = state_q;
        arm_d     = 1'b0;
        phase_d   = phase_q;
        half_d    = half_q;
        bit_d     = bit_q;
        tx_d      = tx_q;
        wr_d      = wr_q;
        rx_d      = rx_q;
        ta_d      = ta_q;
        rd_data_d = rd_data_q;
        rd_err_d  = rd_err_q;
        unique case (state_q)
            S_IDLE: begin
                phase_d = '0;
                half_d  = 1'b0;
                bit_d   = 5'd0;
                if (cmd_valid) begin
                    wr_d    = cmd_write;
                    tx_d    = {2'b01,
                               cmd_write ? 2'b01 : 2'b10,
                               cmd_phyad, cmd_regad, 2'b10,
                               cmd_write ? cmd_wdata : 16'h0000};
                    arm_d   = 1'b1;
                    state_d = FIRST_STATE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                if (!arm_q) begin
                    if (mdc_tick) begin
                        phase_d = '0;
                        half_d  = !half_q;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                    if (mdc_tick && !half_q) begin
                        if (state_q == S_TA && bit_q == 5'd1) begin
                            ta_d = phy_mdio;
                        end
                        if (state_q == S_DATA) begin
                            rx_d = {rx_q[14:0], phy_mdio};
                        end
                    end
                    if (mdc_tick && half_q) begin
                        bit_d = bit_q + 5'd1;
                        if (state_q != S_PRE) begin
                            tx_d = {tx_q[30:0], 1'b0};
                        end
                        if (bit_q == last_bit) begin
                            bit_d = 5'd0;
                            case (state_q)
                                S_PRE:   state_d = S_HDR;
                                S_HDR:   state_d = S_TA;
                                S_TA:    state_d = S_DATA;
                                default: begin
                                    state_d = S_DONE;
                                    if (!wr_q) begin
                                        rd_data_d = rx_q;
                                        rd_err_d  = ta_q;
                                    end
                                end
                            endcase
                        end
                    end
                end
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            arm_q     <= 1'b0;
            phase_q   <= '0;
            half_q    <= 1'b0;
            bit_q     <= 5'd0;
            tx_q      <= 32'h0;
            wr_q      <= 1'b0;
            rx_q      <= 16'h0;
            ta_q      <= 1'b0;
            rd_data_q <= 16'h0;
            rd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            arm_q     <= arm_d;
            phase_q   <= phase_d;
            half_q    <= half_d;
            bit_q     <= bit_d;
            tx_q      <= tx_d;
            wr_q      <= wr_d;
            rx_q      <= rx_d;
            ta_q      <= ta_d;
            rd_data_q <= rd_data_d;
            rd_err_q  <= rd_err_d;
        end
    end

    // Line driver: preamble ones, then header MSB first; reads release
    // the line for turnaround and data.
    always_comb begin
        mdo    = (state_q == S_PRE) ? 1'b1 : tx_q[31];
        mdo_en = 1'b0;
        if (!arm_q) begin
            case (state_q)
                S_PRE, S_HDR:  mdo_en = 1'b1;
                S_TA, S_DATA:  mdo_en = wr_q;
                default:       mdo_en = 1'b0;
            endcase
        end
    end

    assign phy_mdio  = mdo_en ? mdo : 1'bz;
    assign phy_mdc   = half_q;
    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = !cmd_ready;
    assign done      = (state_q == S_DONE);
    assign rd_data   = rd_data_q;
    assign rd_err    = rd_err_q;

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed bench for mdio_master with a small PHY model.
// Frame bits are captured on every MDC rising edge.
module tb_mdio_master;

    localparam int CLK_DIV = 10;
`ifdef MDIO_PRE_SUPPRESS_EN
    localparam int PRE = 0;
`else
    localparam int PRE = 32;
`endif
    localparam int FB  = PRE + 32;
    localparam int LAT = 1 + FB * 2 * CLK_DIV;
    localparam int GAP = LAT + 2;
    localparam int TMO = 4 * LAT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_phyad = 5'h0;
    logic [4:0]  cmd_regad = 5'h0;
    logic [15:0] cmd_wdata = 16'h0;
    logic        cmd_ready;
    logic [15:0] rd_data;
    logic        rd_err;
    logic        done;
    logic        busy;
    logic        phy_mdc;
    wire         mdio;

    int cyc   = 0;
    int nvec  = 0;
    int nfail = 0;

    int          nbits = 0;
    int          base  = 0;
    logic [63:0] frame_q = '0;
    logic        phy_oe = 1'b0;
    logic        phy_out = 1'b1;
    logic        phy_rd = 1'b0;
    logic        phy_en = 1'b0;
    logic [15:0] phy_data = 16'h0;

    pullup (mdio);
    assign mdio = phy_oe ? phy_out : 1'bz;

    mdio_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_phyad (cmd_phyad),
        .cmd_regad (cmd_regad),
        .cmd_wdata (cmd_wdata),
        .rd_data   (rd_data),
        .rd_err    (rd_err),
        .done      (done),
        .busy      (busy),
        .phy_mdc   (phy_mdc),
        .phy_mdio  (mdio)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame capture plus a PHY that answers reads: TA Z/0 then data.
    always @(posedge phy_mdc) begin
        int rel;
        int idx;
        frame_q = {frame_q[62:0], mdio};
        nbits = nbits + 1;
        rel = nbits - base;
        if (rel == PRE + 15) phy_rd = (frame_q[12:11] == 2'b10);
        if (phy_en && phy_rd && rel >= PRE + 15 && rel <= PRE + 31) begin
            phy_oe = 1'b1;
            if (rel == PRE + 15) begin
                phy_out = 1'b0;
            end else begin
                idx = PRE + 31 - rel;
                phy_out = phy_data[idx[3:0]];
            end
        end else begin
            phy_oe = 1'b0;
        end
    end

    task automatic start_cmd(input logic w, input logic [4:0] pa,
                             input logic [4:0] ra, input logic [15:0] wd,
                             output int acc);
        int t;
        @(negedge clk);
        cmd_write = w;
        cmd_phyad = pa;
        cmd_regad = ra;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int acc, output int lat);
        int t;
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
        end while (done !== 1'b1 && t < TMO);
        lat = cyc - acc;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        repeat (5) @(negedge clk);
        nvec++;
        if (cmd_ready !== 1'b1) begin
            nfail++;
            $display("FAIL rst_ready got=%b exp=1", cmd_ready);
        end
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nfail++;
            $display("FAIL rst_busy_done got=%b%b exp=00", busy, done);
        end
        nvec++;
        if (phy_mdc !== 1'b0 || mdio !== 1'b1) begin
            nfail++;
            $display("FAIL rst_line mdc/mdio got=%b%b exp=01", phy_mdc, mdio);
        end
        nvec++;
        if (rd_data !== 16'h0 || rd_err !== 1'b0) begin
            nfail++;
            $display("FAIL rst_rd got=%h/%b exp=0000/0", rd_data, rd_err);
        end
        nvec++;
        if (nbits !== 0) begin
            nfail++;
            $display("FAIL rst_no_frame got=%0d mdc edges exp=0", nbits);
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        nvec++;
        if (cmd_ready !== 1'b1 || nbits !== 0) begin
            nfail++;
            $display("FAIL rst_release got ready=%b edges=%0d exp=1/0", cmd_ready, nbits);
        end
    endtask

    task automatic test_write;
        int acc, lat;
        logic [63:0] exp;
        exp = {32'hFFFF_FFFF, 32'h5082_3100};
        base = nbits;
        start_cmd(1'b1, 5'h01, 5'h00, 16'h3100, acc);
        wait_done(acc, lat);
        nvec++;
        if (lat !== LAT) begin
            nfail++;
            $display("FAIL wr_latency got=%0d exp=%0d", lat, LAT);
        end
        nvec++;
        if (nbits - base !== FB || frame_q[FB-1:0] !== exp[FB-1:0]) begin
            nfail++;
            $display("FAIL wr_frame got=%0d bits %h exp=%0d bits %h",
                     nbits - base, frame_q, FB, exp);
        end
        nvec++;
        if (rd_data !== 16'h0 || rd_err !== 1'b0) begin
            nfail++;
            $display("FAIL wr_keeps_rd got=%h/%b exp=0000/0", rd_data, rd_err);
        end
        @(posedge clk);
        #1;
        nvec++;
        if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            nfail++;
            $display("FAIL wr_after_done got done/busy/ready=%b%b%b exp=001",
                     done, busy, cmd_ready);
        end
    endtask

    task automatic test_read;
        int acc, lat;
        logic [63:0] exp;
        exp = {32'hFFFF_FFFF, 32'h608A_0022};
        phy_en = 1'b1;
        phy_data = 16'h0022;
        base = nbits;
        start_cmd(1'b0, 5'h01, 5'h02, 16'hFFFF, acc);
        wait_done(acc, lat);
        nvec++;
        if (lat !== LAT) begin
            nfail++;
            $display("FAIL rd_latency got=%0d exp=%0d", lat, LAT);
        end
        nvec++;
        if (rd_data !== 16'h0022 || rd_err !== 1'b0) begin
            nfail++;
            $display("FAIL rd_data got=%h/%b exp=0022/0", rd_data, rd_err);
        end
        nvec++;
        if (nbits - base !== FB || frame_q[FB-1:0] !== exp[FB-1:0]) begin
            nfail++;
            $display("FAIL rd_frame got=%h exp=%h", frame_q, exp);
        end
        phy_en = 1'b0;
    endtask

    task automatic test_missing_phy;
        int acc, lat;
        logic [63:0] exp;
        exp = {32'hFFFF_FFFF, 32'h608B_FFFF};
        phy_en = 1'b0;
        base = nbits;
        start_cmd(1'b0, 5'h01, 5'h02, 16'h0000, acc);
        wait_done(acc, lat);
        nvec++;
        if (rd_data !== 16'hFFFF || rd_err !== 1'b1) begin
            nfail++;
            $display("FAIL nophy_rd got=%h/%b exp=ffff/1", rd_data, rd_err);
        end
        nvec++;
        if (frame_q[FB-1:0] !== exp[FB-1:0]) begin
            nfail++;
            $display("FAIL nophy_line_released got=%h exp=%h", frame_q, exp);
        end
    endtask

    task automatic test_back_to_back;
        int t, early, bad_busy, acc1, acc2, d1, lat;
        logic [63:0] exp_a;
        logic [63:0] exp_b;
        exp_a = {32'hFFFF_FFFF, 32'h5192_A5A5};
        exp_b = {32'hFFFF_FFFF, 32'h6FFE_C35A};
        phy_en = 1'b1;
        phy_data = 16'hC35A;
        base = nbits;
        @(negedge clk);
        cmd_write = 1'b1;
        cmd_phyad = 5'h03;
        cmd_regad = 5'h04;
        cmd_wdata = 16'hA5A5;
        cmd_valid = 1'b1;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1 acc1 = cyc;
        @(negedge clk);
        cmd_write = 1'b0;
        cmd_phyad = 5'h1F;
        cmd_regad = 5'h1F;
        cmd_wdata = 16'h0000;
        early = 0;
        bad_busy = 0;
        t = 0;
        do begin
            @(posedge clk);
            #1;
            t++;
            if (cmd_ready !== 1'b0) early++;
            if (busy === cmd_ready) bad_busy++;
        end while (done !== 1'b1 && t < TMO);
        d1 = cyc;
        nvec++;
        if (d1 - acc1 !== LAT) begin
            nfail++;
            $display("FAIL b2b_lat_a got=%0d exp=%0d", d1 - acc1, LAT);
        end
        nvec++;
        if (early !== 0 || bad_busy !== 0) begin
            nfail++;
            $display("FAIL b2b_ignored got ready=%0d busyerr=%0d exp=0/0",
                     early, bad_busy);
        end
        nvec++;
        if (frame_q[FB-1:0] !== exp_a[FB-1:0]) begin
            nfail++;
            $display("FAIL b2b_frame_a got=%h exp=%h", frame_q, exp_a);
        end
        nvec++;
        if (rd_data !== 16'hFFFF || rd_err !== 1'b1) begin
            nfail++;
            $display("FAIL b2b_write_keeps_rd got=%h/%b exp=ffff/1", rd_data, rd_err);
        end
        base = nbits;
        @(posedge clk);
        #1;
        nvec++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            nfail++;
            $display("FAIL b2b_idle_gap got ready/busy=%b%b exp=10", cmd_ready, busy);
        end
        @(posedge clk);
        #1 acc2 = cyc;
        nvec++;
        if (cmd_ready !== 1'b0) begin
            nfail++;
            $display("FAIL b2b_accept_b got ready=%b exp=0", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_done(acc2, lat);
        nvec++;
        if (cyc - d1 !== GAP) begin
            nfail++;
            $display("FAIL b2b_gap got=%0d exp=%0d", cyc - d1, GAP);
        end
        nvec++;
        if (frame_q[FB-1:0] !== exp_b[FB-1:0]) begin
            nfail++;
            $display("FAIL b2b_frame_b got=%h exp=%h", frame_q, exp_b);
        end
        nvec++;
        if (rd_data !== 16'hC35A || rd_err !== 1'b0) begin
            nfail++;
            $display("FAIL b2b_rd_b got=%h/%b exp=c35a/0", rd_data, rd_err);
        end
        phy_en = 1'b0;
    endtask

    task automatic test_midframe_reset;
        int t, acc, lat, ndone;
        logic [63:0] exp;
        exp = {32'hFFFF_FFFF, 32'h596E_8001};
        base = nbits;
        start_cmd(1'b1, 5'h01, 5'h00, 16'h3100, acc);
        t = 0;
        while (nbits - base < PRE + 1 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        nvec++;
        if (mdio !== 1'b0) begin
            nfail++;
            $display("FAIL mid_st_driven got=%b exp=0", mdio);
        end
        #1 rst_n = 1'b0;
        #1;
        nvec++;
        if (mdio !== 1'b1 || phy_mdc !== 1'b0) begin
            nfail++;
            $display("FAIL mid_release got mdio/mdc=%b%b exp=10", mdio, phy_mdc);
        end
        nvec++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rd_data !== 16'h0) begin
            nfail++;
            $display("FAIL mid_outputs got ready/busy/rd=%b%b/%h exp=10/0000",
                     cmd_ready, busy, rd_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) ndone++;
        end
        nvec++;
        if (ndone !== 0) begin
            nfail++;
            $display("FAIL mid_no_done got=%0d pulses exp=0", ndone);
        end
        base = nbits;
        start_cmd(1'b1, 5'h12, 5'h1B, 16'h8001, acc);
        wait_done(acc, lat);
        nvec++;
        if (lat !== LAT) begin
            nfail++;
            $display("FAIL mid_next_lat got=%0d exp=%0d", lat, LAT);
        end
        nvec++;
        if (nbits - base !== FB || frame_q[FB-1:0] !== exp[FB-1:0]) begin
            nfail++;
            $display("FAIL mid_next_frame got=%h exp=%h", frame_q, exp);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_missing_phy();
        test_back_to_back();
        test_midframe_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/mdio_master.md
# mdio_master

Clause-22 MDIO management controller that configures and monitors the Ethernet PHY attached to the MII datapath, driving `phy_mdc` and the bidirectional `phy_mdio` line. It accepts one register read or write command at a time through a valid/ready handshake, serialises the management frame, and returns read data with a turnaround error flag. It sits beside the MAC/FIFO datapath in the bridge top level and runs in the system `clk` domain.

## Interface
- `CLK_DIV`, default 10: `clk` cycles per MDC half-period; legal range ≥ 2. The default gives 1.25 MHz MDC from a 25 MHz `clk`.
- `clk` input 1: system clock; all logic is on its rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `cmd_valid` input 1: a command is presented.
- `cmd_ready` output 1: the controller is idle and can accept a command.
- `cmd_write` input 1: 1 = write (OP 01), 0 = read (OP 10).
- `cmd_phyad` input 5: PHY address.
- `cmd_regad` input 5: register address.
- `cmd_wdata` input 16: write data.
- `rd_data` output 16: last read value; holds until the next read completes.
- `rd_err` output 1: the PHY did not drive 0 in the second TA bit of the last read.
- `done` output 1: one-cycle pulse at the end of every frame.
- `busy` output 1: a frame is in progress.
- `phy_mdc` output 1: management clock; low when idle.
- `phy_mdio` inout 1: management data; high-Z when not driven by this block.

## Operation
- Command acceptance:
  - A command is accepted on the rising edge where `cmd_valid && cmd_ready`.
  - All `cmd_*` fields are captured on that edge.
  - `cmd_ready` falls on the next cycle.
  - `cmd_valid` while `cmd_ready=0` is ignored and never queued.
- States: IDLE → PRE → HDR → TA → DATA → DONE → IDLE.
  - PRE: 32 bits of 1.
  - HDR: 14 bits = ST 01, OP, PHYAD[4:0], REGAD[4:0], each field MSB first.
  - TA: 2 bits.
  - DATA: 16 bits, MSB first.
  - DONE: one `clk` cycle.
- Write frames:
  - The block drives every bit, including TA = 1,0.
  - `phy_mdio` output enable stays asserted from the first PRE bit through the last DATA bit.
- Read frames:
  - The block drives PRE and HDR, then releases `phy_mdio` (high-Z) for both TA bits and all DATA bits.
  - The second TA bit is sampled; a value of 1 sets `rd_err=1`, a value of 0 gives `rd_err=0`.
  - The 16 DATA bits are shifted into `rd_data` MSB first.
  - `rd_data` and `rd_err` update in the DONE cycle.
  - A write leaves `rd_data` and `rd_err` unchanged.
- In the DONE cycle, `done=1` and `busy=0` from the following cycle. `cmd_ready=1` on the cycle after DONE.
- `busy = !cmd_ready` except in reset.
- Undriven MDIO reads 1 through the board pull-up; a missing PHY therefore yields `rd_data=16'hFFFF` and `rd_err=1`.

## Timing
- Reset values: `cmd_ready=1`, `busy=0`, `done=0`, `rd_data=0`, `rd_err=0`, `phy_mdc=0`, `phy_mdio` high-Z.
- Bit period is 2·CLK_DIV `clk` cycles:
  - first CLK_DIV cycles: MDC low;
  - last CLK_DIV cycles: MDC high.
- Bit value changes on the first `clk` of the low half, which gives CLK_DIV cycles of setup and hold around the MDC rising edge.
- Read sampling: `phy_mdio` is registered on the `clk` edge where `phy_mdc` goes 0→1.
- The first PRE bit's low half begins on the cycle after acceptance.
- `done` pulses exactly 1 + 64·2·CLK_DIV cycles after acceptance (1281 at default). With preamble suppression it is 1 + 32·2·CLK_DIV (641).
- Back-to-back commands: the minimum gap between `done` pulses is the frame length plus 2 cycles (DONE plus one idle cycle with `cmd_ready=1`).
- Reset mid-frame:
  - Outputs return to reset values asynchronously and `phy_mdio` is released immediately.
  - The frame is abandoned and no `done` pulse is generated.
- The MDC phase counter wraps at CLK_DIV−1. It is held at 0 in IDLE, so every frame starts phase-aligned.

## Configuration
- `MDIO_PRE_SUPPRESS_EN`:
  - Defined: the PRE state is skipped (IDLE → HDR) and frames are 32 bits. This is for PHYs that support preamble suppression.
  - Undefined: the full 32-bit preamble is sent and frames are 64 bits.
- No other behaviour changes with this macro.

## Test plan
- Reset check: hold `rst_n=0` and drive `cmd_valid=1` → `cmd_ready=1`, `phy_mdc=0`, `phy_mdio`=Z, no frame starts until release.
- Write frame: PHYAD=5'h01, REGAD=5'h00, WDATA=16'h3100, CLK_DIV=10 → decoded frame is 32×1, 01, 01, 00001, 00000, 10, 0011000100000000; `done` arrives 1281 cycles after acceptance.
- Normal read: PHYAD=5'h01, REGAD=5'h02; the PHY model drives TA Z/0 and data 16'h0022 → `rd_data=16'h0022`, `rd_err=0`, and `phy_mdio` is not driven by the DUT during TA and DATA.
- Missing PHY: read with no PHY driving and the line pulled up → `rd_data=16'hFFFF`, `rd_err=1`.
- Handshake: assert `cmd_valid` continuously with two different commands → the second is accepted only on the cycle after DONE; the intervening valid cycles are ignored; two `done` pulses are 1283 cycles apart.
- Mid-frame reset: pulse `rst_n` low during HDR → `phy_mdio` goes Z within the same cycle, no `done` pulse, and the next command yields a correct full frame (also run with `MDIO_PRE_SUPPRESS_EN`, where `done` arrives at 641 cycles).
